// File: rtl/rr_request_source_if.sv
// Bus between the requester-side job source and its environment: job inputs
// and arbiter grants in, request/debug outputs back out.
// Grant semantics (no ready signal exists): the arbiter holds grant_in[i] high
// for a slice. A slice counts as served only when it lasted at least
// MIN_GRANT_CYCLES consecutive one-hot-or-zero cycles and then drops. job_done
// is a single-cycle pulse, and the environment never needs to acknowledge it.
interface rr_request_source_if #(
   parameter int CNT_W = 3
);
   logic [3:0]         job_in;
   logic [3:0]         grant_in;
   logic [3:0]         request_queue;
   logic [3:0]         job_done;
   logic [4*CNT_W-1:0] pending_count;
   logic [3:0]         overflow;
   logic               protocol_err;

   // Environment side: drives jobs and grants, observes requests and flags.
   modport master (
      output job_in, grant_in,
      input  request_queue, job_done, pending_count, overflow, protocol_err
   );

   // Block side.
   modport slave (
      input  job_in, grant_in,
      output request_queue, job_done, pending_count, overflow, protocol_err
   );
endinterface

// File: rtl/rr_request_source.sv
// Per-line pending-job counters feeding a four-line round robin arbiter.
// A rising job edge enqueues one job. A served grant slice retires one job.
// Malformed grants raise sticky debug flags.
module rr_request_source #(
   parameter int CNT_W            = 3,
   parameter int MIN_GRANT_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   rr_request_source_if.slave bus
);
   localparam int HW = $clog2(MIN_GRANT_CYCLES + 1);
   localparam logic [HW-1:0]    HOLD_MAX = HW'(MIN_GRANT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [CNT_W-1:0] count_q [4];
   logic [CNT_W-1:0] count_d [4];
   logic [HW-1:0]    hold_q  [4];
   logic [HW-1:0]    hold_d  [4];
   logic [3:0]       job_prev_q;
   logic [3:0]       job_done_q, job_done_d;
   logic [3:0]       overflow_q, overflow_d;
   logic             protocol_err_q, protocol_err_d;

   logic [3:0]       push;
   logic [3:0]       compl;
   logic             multi_hot;

   // Event detection: job rising edges, multi-hot grants, finished slices.
   always_comb begin
      multi_hot = |(bus.grant_in & (bus.grant_in - 4'd1));
      push      = bus.job_in & ~job_prev_q;
      compl     = '0;
      for (int i = 0; i < 4; i++) begin
         compl[i] = !bus.grant_in[i] && (hold_q[i] >= HOLD_MAX);
      end
   end

   // Next-state for hold timers, counters and flags.
   always_comb begin
      job_done_d     = '0;
      overflow_d     = overflow_q;
      protocol_err_d = protocol_err_q || multi_hot;
      for (int i = 0; i < 4; i++) begin
         count_d[i] = count_q[i];
         hold_d[i]  = '0;
         // A multi-hot cycle clears every timer and accrues nothing.
         if (!multi_hot && bus.grant_in[i]) begin
            hold_d[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + 1'b1;
         end
         unique case ({push[i], compl[i]})
            2'b10: begin
               if (count_q[i] == CNT_MAX) overflow_d[i] = 1'b1;
               else count_d[i] = count_q[i] + 1'b1;
            end
            2'b01: begin
               if (count_q[i] == '0) protocol_err_d = 1'b1;
               else begin
                  count_d[i]    = count_q[i] - 1'b1;
                  job_done_d[i] = 1'b1;
               end
            end
            2'b11: begin
               // The new job replaces the retired one, so no overflow is possible.
               if (count_q[i] == '0) begin
                  count_d[i]     = {{(CNT_W-1){1'b0}}, 1'b1};
                  protocol_err_d = 1'b1;
               end else begin
                  job_done_d[i] = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            count_q[i] <= '0;
            hold_q[i]  <= '0;
         end
         job_prev_q     <= '0;
         job_done_q     <= '0;
         overflow_q     <= '0;
         protocol_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            count_q[i] <= count_d[i];
            hold_q[i]  <= hold_d[i];
         end
         job_prev_q     <= bus.job_in;
         job_done_q     <= job_done_d;
         overflow_q     <= overflow_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_out
      assign bus.request_queue[g]                  = |count_q[g];
      assign bus.pending_count[g*CNT_W +: CNT_W]   = count_q[g];
   end
   assign bus.job_done     = job_done_q;
   assign bus.overflow     = overflow_q;
   assign bus.protocol_err = protocol_err_q;
endmodule

// File: tb/tb_rr_request_source.sv
// Directed bench for rr_request_source. The driver pushes expected snapshots
// and job_done events into queues, and a negedge monitor pops and compares.
module tb_rr_request_source;
   localparam int CNT_W = 3;
   localparam int MGC   = 4;
   localparam int W     = 4 + 4*CNT_W + 4 + 1;

   logic clk;
   logic reset;
   rr_request_source_if #(.CNT_W(CNT_W)) bus ();

   rr_request_source #(.CNT_W(CNT_W), .MIN_GRANT_CYCLES(MGC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard
   logic [W-1:0] exp_q[$];
   string        name_q[$];
   logic [3:0]   done_q[$];
   int           snap_req    = 0;
   int           snap_served = 0;
   logic         end_req     = 1'b0;
   logic         mon_done    = 1'b0;
   int           n_cmp       = 0;
   int           n_fail      = 0;

   // monitor: compares job_done pulses and requested snapshots at negedge
   always @(negedge clk) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      logic [3:0]   exp_done;
      string        nm;
      if (bus.job_done != 4'b0000) begin
         n_cmp++;
         if (done_q.size() == 0) begin
            n_fail++;
            $display("FAIL job_done_unexpected: got %b, required none", bus.job_done);
         end else begin
            exp_done = done_q.pop_front();
            if (bus.job_done != exp_done) begin
               n_fail++;
               $display("FAIL job_done: got %b, required %b", bus.job_done, exp_done);
            end
         end
      end
      while (snap_served != snap_req) begin
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {bus.request_queue, bus.pending_count, bus.overflow, bus.protocol_err};
         n_cmp++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rq=%b pc=%h ov=%b err=%b, required rq=%b pc=%h ov=%b err=%b",
                     nm, act[W-1 -: 4], act[W-5 -: 4*CNT_W], act[4:1], act[0],
                     exp[W-1 -: 4], exp[W-5 -: 4*CNT_W], exp[4:1], exp[0]);
         end
         snap_served++;
      end
      if (end_req && !mon_done) begin
         n_cmp++;
         if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL job_done_missing: got %0d pulses outstanding, required 0", done_q.size());
         end
         mon_done = 1'b1;
      end
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic push(input int line);
      bus.job_in[line] = 1'b1;
      step(1);
      bus.job_in[line] = 1'b0;
      step(1);
   endtask

   task automatic grant(input int line, input int n);
      bus.grant_in = 4'b0001 << line;
      step(n);
      bus.grant_in = 4'b0000;
      step(1);
   endtask

   task automatic expect_snap(input string nm, input logic [3:0] rq,
                              input logic [4*CNT_W-1:0] pc, input logic [3:0] ov,
                              input logic err);
      exp_q.push_back({rq, pc, ov, err});
      name_q.push_back(nm);
      snap_req++;
   endtask

   initial begin
      reset        = 1'b1;
      bus.job_in   = 4'b0000;
      bus.grant_in = 4'b0000;
      step(1);
      do_reset();
      expect_snap("reset_state", 4'b0000, 12'h000, 4'b0000, 1'b0);

      // basic enqueue and retire on line 2
      repeat (3) push(2);
      expect_snap("enqueue3_line2", 4'b0100, 12'h0C0, 4'b0000, 1'b0);
      done_q.push_back(4'b0100);
      grant(2, 6);
      expect_snap("retire_line2", 4'b0100, 12'h080, 4'b0000, 1'b0);

      // short grant ignored on line 1
      push(1);
      expect_snap("enqueue_line1", 4'b0110, 12'h088, 4'b0000, 1'b0);
      grant(1, 3);
      step(1);
      expect_snap("short_grant", 4'b0110, 12'h088, 4'b0000, 1'b0);

      // overflow on line 0
      repeat (8) push(0);
      expect_snap("overflow_line0", 4'b0111, 12'h08F, 4'b0001, 1'b0);

      // fill line 3, then push and completion at the same edge
      repeat (7) push(3);
      expect_snap("fill_line3", 4'b1111, 12'hE8F, 4'b0001, 1'b0);
      bus.grant_in = 4'b1000;
      step(5);
      bus.grant_in  = 4'b0000;
      bus.job_in[3] = 1'b1;
      done_q.push_back(4'b1000);
      step(1);
      bus.job_in[3] = 1'b0;
      step(1);
      expect_snap("push_and_retire_max", 4'b1111, 12'hE8F, 4'b0001, 1'b0);

      // multi-hot grant clears hold time: 3 + (cleared) + 2 never completes
      bus.grant_in = 4'b0001;
      step(3);
      bus.grant_in = 4'b0011;
      step(1);
      bus.grant_in = 4'b0001;
      step(2);
      bus.grant_in = 4'b0000;
      step(2);
      expect_snap("multi_hot", 4'b1111, 12'hE8F, 4'b0001, 1'b1);

      // stray completed grant on an empty line
      do_reset();
      expect_snap("fresh_reset", 4'b0000, 12'h000, 4'b0000, 1'b0);
      grant(3, 5);
      step(1);
      expect_snap("stray_grant", 4'b0000, 12'h000, 4'b0000, 1'b1);

      // reset in the middle of a grant
      do_reset();
      repeat (2) push(0);
      push(1);
      repeat (3) push(3);
      expect_snap("counts_2_1_0_3", 4'b1011, 12'h60A, 4'b0000, 1'b0);
      bus.grant_in = 4'b0001;
      step(5);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      expect_snap("reset_mid_grant", 4'b0000, 12'h000, 4'b0000, 1'b0);
      step(2);
      bus.grant_in = 4'b0000;
      step(2);
      expect_snap("grant_fall_after_reset", 4'b0000, 12'h000, 4'b0000, 1'b0);

      // job held high through reset release enqueues once
      bus.job_in[2] = 1'b1;
      do_reset();
      step(1);
      expect_snap("job_held_through_reset", 4'b0100, 12'h040, 4'b0000, 1'b0);
      step(3);
      expect_snap("job_held_no_repeat", 4'b0100, 12'h040, 4'b0000, 1'b0);
      bus.job_in[2] = 1'b0;
      step(2);

      end_req = 1'b1;
      for (int k = 0; k < 20 && !mon_done; k++) step(1);
      if (!mon_done) begin
         $display("FAIL monitor_timeout: got no end handshake, required one within 20 cycles");
         $fatal(1, "monitor did not finish");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/rr_request_source.md
# rr_request_source

Requester-side companion to the four-line round robin arbiter: holds a pending-job count per request line, drives the arbiter's `request_queue` while jobs are pending, and retires one job each time that line completes a valid grant slice. Job inputs are level signals, typically debounced buttons on the FPGA board; each rising edge enqueues one job. The block also flags protocol errors on the grant bus, such as multi-hot or stray grants, for the LED/debug outputs.

## Interface
Parameters:
- `CNT_W`, default 3: width of each per-line job counter; max pending jobs = 2^CNT_W − 1.
- `MIN_GRANT_CYCLES`, default 4: minimum consecutive high cycles for a grant to count as a served slice (≥1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `job_in`  in  4  level job inputs; each 0→1 transition on bit i enqueues one job on line i.
- `grant_in`  in  4  grant bus from the arbiter; expected one-hot or zero.
- `request_queue`  out  4  bit i = 1 while line i has a pending count ≠ 0.
- `job_done`  out  4  one-cycle pulse on bit i when a job on line i retires.
- `pending_count`  out  4*CNT_W  packed counts; line i at [i*CNT_W +: CNT_W].
- `overflow`  out  4  sticky; bit i set when a job arrives on line i while its count is full.
- `protocol_err`  out  1  sticky; set on a multi-hot grant or a completed grant on a line with count 0.

## Operation
- Per line i, the block holds these registers:
  - `count_i` (CNT_W bits)
  - `job_prev_i`
  - `hold_i`, saturating at MIN_GRANT_CYCLES, width clog2(MIN_GRANT_CYCLES+1)
- Push event: `job_in[i]=1` and `job_prev_i=0` at a clock edge. `job_prev_i` follows `job_in[i]` every cycle.
- Grant tracking:
  - **Valid grant:** `grant_in` is one-hot or zero in that cycle.
  - On a valid cycle with `grant_in[i]=1`, `hold_i` increments and saturates.
  - On a cycle with `grant_in[i]=0`, `hold_i` clears.
- **Multi-hot grant:** more than one bit of `grant_in` is high.
  - Set `protocol_err`.
  - Clear all `hold_i`.
  - No line accrues hold time in that cycle.
- Completion event on line i: `grant_in[i]=0` and `hold_i ≥ MIN_GRANT_CYCLES` at the edge.
  - A grant shorter than MIN_GRANT_CYCLES is ignored: no retire, no error.
- Count update per line. Push and completion are evaluated independently in the same edge:
  - Push only, count < max: count+1.
  - Push only, count = max: count unchanged, `overflow[i]` ← 1.
  - Completion only, count > 0: count−1, `job_done[i]` pulses.
  - Completion only, count = 0: count unchanged, no pulse, `protocol_err` ← 1.
  - Push and completion together, count > 0: count unchanged, `job_done[i]` pulses, no overflow, even at max.
  - Push and completion together, count = 0: count ← 1, no pulse, `protocol_err` ← 1.
- `request_queue[i]` = (`count_i` ≠ 0), combinational from the count register.
- A grant that stays high indefinitely never completes. `hold_i` remains saturated.
- Sticky flags clear only on reset.

## Timing
- All state updates on posedge `clk`. Reset has priority over all events.
- Reset values:
  - All counts = 0.
  - `request_queue` = 0, `job_done` = 0, `pending_count` = 0.
  - `overflow` = 0, `protocol_err` = 0.
  - `job_prev` = 0, `hold` = 0.
- Consequence: a `job_in` bit held high through reset release enqueues one job on the first edge after reset.
- Push latency:
  - The edge sampling the rising `job_in` updates the count.
  - `request_queue` and `pending_count` reflect it from that edge onward, 1 cycle after the input rises.
- Retire latency:
  - `job_done` is registered and high for exactly the one cycle following the edge that sampled `grant_in[i]` low.
  - The count and `request_queue` change at that same edge.
- The arbiter's grant slice is 3 s at 50 MHz on the board. Simulation uses a small THREE_SECS_FREQ with MIN_GRANT_CYCLES ≤ the slice length.
- Reset asserted mid-grant:
  - Hold, counts and flags clear.
  - A grant falling after reset release does not retire a job.

## Test plan
- **Basic enqueue and retire:** reset, then pulse `job_in[2]` 3× with gaps.
  - Expect `pending_count` line 2 = 3 and `request_queue` = 4'b0100.
  - Then apply `grant_in` = 4'b0100 for 6 cycles and drop it: count = 2, one `job_done[2]` pulse, `request_queue` still 4'b0100.
- **Short grant ignored:** count1 = 1, `grant_in` = 4'b0010 for 3 cycles with MIN_GRANT_CYCLES = 4.
  - Expect count unchanged, no `job_done`, `protocol_err` = 0.
- **Overflow:** CNT_W = 3, 8 rising edges on `job_in[0]`.
  - Expect count0 = 7 and `overflow` = 4'b0001.
  - Expect the other lines' overflow bits stay 0.
- **Simultaneous push and completion at max:** count3 = 7, then the `job_in[3]` rising edge and the `grant_in[3]` fall are sampled at the same edge after a 5-cycle grant.
  - Expect count3 = 7, `job_done[3]` pulse, `overflow[3]` = 0.
- **Protocol errors:**
  - `grant_in` = 4'b0011 for 1 cycle: `protocol_err` = 1, all hold counters cleared.
  - After a fresh reset, a 5-cycle `grant_in` = 4'b1000 with count3 = 0: `protocol_err` = 1, count3 stays 0.
- **Reset mid-operation:** counts {2,1,0,3} on lines {0,1,2,3}, with `grant_in[0]` high for 5 cycles; assert reset for 1 cycle.
  - Expect all outputs 0 on the next cycle.
  - Expect the subsequent fall of `grant_in[0]` to produce no `job_done`.
